// File: rtl/npc_ctrl_pkg.sv
// Shared constants and types for the next-PC controller.
package npc_ctrl_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned CNT_W    = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180;

  // RUN: normal fetch; PEND: a redirect is parked behind a stall
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } npc_state_e;

  // Word fetch requires the low two address bits to be zero
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational branch / jump / register-jump target generation for decode.
module npc_target_calc
  import npc_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_req,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic              j_req,
  input  logic [JIDX_W-1:0] j_index,
  input  logic              jr_req,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_target
);

  logic [ADDR_W-1:0] dec_seq;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;

  assign dec_seq   = br_pc + 32'd4;
  assign br_off    = {{(ADDR_W-IMM_W-2){br_imm[IMM_W-1]}}, br_imm, 2'b00};
  assign br_target = dec_seq + br_off;
  assign j_target  = {dec_seq[31:28], j_index, 2'b00};

  // Select the one active decode request (requests are mutually exclusive)
  always_comb begin
    dec_valid  = 1'b0;
    dec_target = br_target;
    if (jr_req) begin
      dec_valid  = 1'b1;
      dec_target = jr_target;
    end else if (j_req) begin
      dec_valid  = 1'b1;
      dec_target = j_target;
    end else if (br_req && br_taken) begin
      dec_valid  = 1'b1;
      dec_target = br_target;
    end
  end

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC generator: priority mux over reset/exception/eret/pending/decode/sequential,
// with a one-entry pending redirect held across fetch stalls.
module npc_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_VEC_P  = EXC_VEC,
  parameter int unsigned       CNT_W_P    = CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                stall,
  input  logic                br_req,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_pc,
  input  logic [IMM_W-1:0]    br_imm,
  input  logic                j_req,
  input  logic [JIDX_W-1:0]   j_index,
  input  logic                jr_req,
  input  logic [ADDR_W-1:0]   jr_target,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [ADDR_W-1:0]   epc,
  output logic [ADDR_W-1:0]   next_pc,
  output logic                pc_en,
  output logic                adel_f,
  output logic [CNT_W_P-1:0]  redirect_cnt
);

  npc_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic              pend_valid;
  logic              cnt_inc;
  logic              dec_valid;
  logic [ADDR_W-1:0] dec_target;

  // The pending entry is valid exactly while parked in PEND
  assign pend_valid = (state == PEND);

  npc_target_calc u_target (
    .br_pc      (br_pc),
    .br_req     (br_req),
    .br_taken   (br_taken),
    .br_imm     (br_imm),
    .j_req      (j_req),
    .j_index    (j_index),
    .jr_req     (jr_req),
    .jr_target  (jr_target),
    .dec_valid  (dec_valid),
    .dec_target (dec_target)
  );

  // State, pending target and redirect counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pend_target  <= '0;
      redirect_cnt <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
      if (cnt_inc) redirect_cnt <= redirect_cnt + CNT_W_P'(1);
    end
  end

  // Next-state and next-PC selection in priority order
  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    cnt_inc         = 1'b0;
    next_pc         = pc + 32'd4;
    pc_en           = 1'b1;
    if (reset) begin
      next_pc = RESET_PC_P;
    end else if (exc_req) begin
      next_pc   = EXC_VEC_P;
      cnt_inc   = 1'b1;
      state_nxt = RUN;
    end else if (eret_req) begin
      next_pc   = epc;
      cnt_inc   = 1'b1;
      state_nxt = RUN;
    end else begin
      unique case (state)
        PEND: begin
          next_pc = pend_target;
          if (stall && pend_valid) begin
            pc_en = 1'b0;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: begin
          if (stall) begin
            pc_en   = 1'b0;
            next_pc = pc;
            if (dec_valid) begin
              pend_target_nxt = dec_target;
              state_nxt       = PEND;
            end
          end else if (dec_valid) begin
            next_pc = dec_target;
            cnt_inc = 1'b1;
          end
        end
      endcase
    end
  end

  // Misaligned fetch flag on the address actually being loaded
  assign adel_f = !reset && pc_en && misaligned(next_pc);

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them.
module tb_npc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        br_req, br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic        j_req;
  logic [25:0] j_index;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        exc_req, eret_req;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        pc_en, adel_f;
  logic [15:0] redirect_cnt;

  typedef struct {
    string       name;
    logic        chk_pc;
    logic [31:0] npc;
    logic        en;
    logic        adel;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  npc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .br_req       (br_req),
    .br_taken     (br_taken),
    .br_pc        (br_pc),
    .br_imm       (br_imm),
    .j_req        (j_req),
    .j_index      (j_index),
    .jr_req       (jr_req),
    .jr_target    (jr_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .next_pc      (next_pc),
    .pc_en        (pc_en),
    .adel_f       (adel_f),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  // Decode requests must be mutually exclusive
  always @(negedge clk) begin
    if (reset === 1'b0)
      assert ($countones({br_req, j_req, jr_req}) <= 1)
        else $error("multiple decode requests");
  end

  // Monitor: compare the oldest expectation against the DUT each cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_pc) begin
        n_cmp++;
        if (next_pc !== e.npc) begin
          n_bad++;
          $display("FAIL %s next_pc got %h want %h", e.name, next_pc, e.npc);
        end
      end
      n_cmp++;
      if (pc_en !== e.en) begin
        n_bad++;
        $display("FAIL %s pc_en got %b want %b", e.name, pc_en, e.en);
      end
      n_cmp++;
      if (adel_f !== e.adel) begin
        n_bad++;
        $display("FAIL %s adel_f got %b want %b", e.name, adel_f, e.adel);
      end
      n_cmp++;
      if (redirect_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s redirect_cnt got %h want %h", e.name, redirect_cnt, e.cnt);
      end
    end
  end

  task automatic idle_inputs();
    stall = 0; br_req = 0; br_taken = 0; br_pc = '0; br_imm = '0;
    j_req = 0; j_index = '0; jr_req = 0; jr_target = '0;
    exc_req = 0; eret_req = 0; epc = '0;
  endtask

  // Advance to the next cycle; inputs are set by the caller afterwards
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic expect_out(input string name, input logic chk_pc, input logic [31:0] npc,
                            input logic en, input logic adel, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.chk_pc = chk_pc; e.npc = npc; e.en = en; e.adel = adel; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int wait_cyc;
    reset = 1'b1;
    pc    = 32'h0;
    idle_inputs();

    // Reset held two cycles
    next_cycle(); reset = 1;
    expect_out("reset0", 1, 32'h3000, 1, 0, 16'h0);
    next_cycle(); reset = 1;
    expect_out("reset1", 1, 32'h3000, 1, 0, 16'h0);

    // Sequential fetch after release
    next_cycle(); reset = 0; pc = 32'h3000;
    expect_out("seq", 1, 32'h3004, 1, 0, 16'h0);

    // Taken backward branch, unstalled
    next_cycle(); pc = 32'h3004;
    br_req = 1; br_taken = 1; br_pc = 32'h3010; br_imm = 16'hFFFE;
    expect_out("br_taken", 1, 32'h300C, 1, 0, 16'h0);

    // Not-taken branch falls through
    next_cycle(); pc = 32'h300C;
    br_req = 1; br_taken = 0; br_pc = 32'h3008; br_imm = 16'h0010;
    expect_out("br_not_taken", 1, 32'h3010, 1, 0, 16'h1);

    // Jump held behind a three-cycle stall
    next_cycle(); pc = 32'h3010; stall = 1;
    j_req = 1; br_pc = 32'h3020; j_index = 26'h000C40;
    expect_out("j_stall0", 0, 32'h0, 0, 0, 16'h1);
    next_cycle(); pc = 32'h3010; stall = 1;
    j_req = 1; br_pc = 32'h3020; j_index = 26'h000C40;
    expect_out("j_stall1", 0, 32'h0, 0, 0, 16'h1);
    next_cycle(); pc = 32'h3010; stall = 1;
    j_req = 1; br_pc = 32'h3020; j_index = 26'h0;
    expect_out("j_stall2", 0, 32'h0, 0, 0, 16'h1);
    next_cycle(); pc = 32'h3010;
    expect_out("j_release", 1, 32'h3100, 1, 0, 16'h1);
    next_cycle(); pc = 32'h3100;
    expect_out("after_pend", 1, 32'h3104, 1, 0, 16'h2);

    // Exception while a redirect is pending discards it
    next_cycle(); pc = 32'h3104; stall = 1;
    jr_req = 1; jr_target = 32'h3200;
    expect_out("jr_stall", 0, 32'h0, 0, 0, 16'h2);
    next_cycle(); pc = 32'h3104; stall = 1; exc_req = 1;
    expect_out("exc_in_pend", 1, 32'h4180, 1, 0, 16'h2);
    next_cycle(); pc = 32'h4180;
    expect_out("pend_dropped", 1, 32'h4184, 1, 0, 16'h3);

    // Eret overrides stall
    next_cycle(); pc = 32'h4184; stall = 1; eret_req = 1; epc = 32'h3050;
    expect_out("eret", 1, 32'h3050, 1, 0, 16'h3);

    // Misaligned register jump target
    next_cycle(); pc = 32'h3050; jr_req = 1; jr_target = 32'h3002;
    expect_out("jr_misalign", 1, 32'h3002, 1, 1, 16'h4);
    next_cycle(); pc = 32'h3002;
    expect_out("seq_misalign", 1, 32'h3006, 1, 1, 16'h5);

    // Exception wins over eret
    next_cycle(); pc = 32'h3006; exc_req = 1; eret_req = 1; epc = 32'h3050;
    expect_out("exc_over_eret", 1, 32'h4180, 1, 0, 16'h5);
    next_cycle(); pc = 32'h4180;
    expect_out("post_exc", 1, 32'h4184, 1, 0, 16'h6);

    // Counter wrap: reset, 65535 redirects, then one more
    next_cycle(); reset = 1;
    for (int i = 0; i < 65535; i++) begin
      next_cycle(); reset = 0; pc = 32'h0; j_req = 1; j_index = 26'h000100;
    end
    next_cycle(); pc = 32'h0400; j_req = 1; br_pc = 32'h1000_0000; j_index = 26'h000010;
    expect_out("cnt_max", 1, 32'h1000_0040, 1, 0, 16'hFFFF);
    next_cycle(); pc = 32'h1000_0040;
    expect_out("cnt_wrap", 1, 32'h1000_0044, 1, 0, 16'h0000);

    // Drain the scoreboard with a bound
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
